sort_deskew_serializer: RTL and testbench

Downstream companion to the 4-input pipelined sorter. Generates the sorter's shared enable, tracks which pipeline slots hold real groups, and re-aligns the sorter's staggered outputs into one coherent 4-word group. It buffers up to two groups and streams each group out one word at a time over a valid/ready handshake. It is the only source of backpressure into the sorter.

---
 rtl/sort_deskew_serializer.sv | 141 ++++++++++++++
 tb/tb_sort_deskew_serializer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_deskew_serializer.sv
// sort_deskew_serializer
// Sits downstream of the 4-input pipelined sorter. It owns the sorter's shared
// enable, tracks which sorter pipeline slots carry real groups, re-aligns the
// staggered sorter outputs into one 4-word group, buffers up to two groups and
// streams each group out one word per valid/ready transfer.
module sort_deskew_serializer #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grp_valid,
  output logic             grp_ready,
  output logic             sort_en,
  input  logic [width-1:0] srt1,
  input  logic [width-1:0] srt2,
  input  logic [width-1:0] srt3,
  input  logic [width-1:0] srt4,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  // One buffered group; element [k] is the word emitted at index k.
  typedef logic [3:0][width-1:0] group_t;

  // Sorter pipeline occupancy: tag[k] set means slot k holds a real group.
  logic [2:0]       tag;

  // Delay lines that line srt4 and srt3 up with srt1/srt2.
  logic [width-1:0] d4a;
  logic [width-1:0] d4b;
  logic [width-1:0] d3a;

  // Two-entry group buffer and its bookkeeping.
  group_t           grp_buf [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       idx;

  logic             full;
  logic             capture;
  logic             xfer;
  logic             pop;
  group_t           aligned;

  // Full comes from registered occupancy only, so a pop on the same edge never
  // frees a slot early and the enable stays free of any out_ready path.
  assign full      = (count == 2'd2);
  assign sort_en   = !(tag[2] && full);
  assign grp_ready = sort_en;

  // A tagged group reaching the end of the pipeline is written whenever the
  // sorter advances; the enable already guarantees a free slot.
  assign capture   = sort_en && tag[2];

  assign out_valid = (count != 2'd0);
  assign out_last  = out_valid && (idx == 2'd3);
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (idx == 2'd3);

  // Word order in the entry: srt1, srt2, delayed srt3, doubly delayed srt4.
  assign aligned   = {d4b, d3a, srt2, srt1};

  // Advance the occupancy tags and the skew delay lines with the sorter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would collapse d4a/d4b into one stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag <= '0;
      d4a <= '0;
      d4b <= '0;
      d3a <= '0;
    end else if (sort_en) begin
      tag <= {tag[1:0], grp_valid};
      d4a <= srt4;
      d4b <= d4a;
      d3a <= srt3;
    end
  end

  // Write the aligned group into the buffer slot at the write pointer.
  // NOTE: the buffer storage is reset on purpose so out_data reads as zero after
  // reset and no stale word from before the reset can ever be presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grp_buf[0] <= '0;
      grp_buf[1] <= '0;
      wr_ptr     <= 1'b0;
    end else if (capture) begin
      grp_buf[wr_ptr] <= aligned;
      wr_ptr          <= ~wr_ptr;
    end
  end

  // Occupancy count: a capture and a pop on the same edge cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
    end else begin
      case ({capture, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Serializer position: each transfer steps the word index, the fourth one
  // wraps it back to zero and retires the head entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= 2'd0;
      rd_ptr <= 1'b0;
    end else if (xfer) begin
      idx <= idx + 2'd1;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Select the current word of the head entry; zero while nothing is offered.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = grp_buf[rd_ptr][idx];
    end
  end

  // Occupancy never exceeds the two buffer entries.
  a_count_range : assert property (@(posedge clk) disable iff (!rst)
    count <= 2'd2);

  // An offered word is held until downstream takes it.
  a_hold_stable : assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

endmodule

// File: tb/tb_sort_deskew_serializer.sv
// Bench for sort_deskew_serializer. A small sorter model (three enabled stages
// with the documented output skew) feeds the DUT; the expected output is a plain
// queue of words, four per accepted group, consumed on every transfer.
module tb_sort_deskew_serializer;
  localparam int W = 8;

  typedef logic [3:0][W-1:0] grp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         grp_valid;
  logic         grp_ready;
  logic         sort_en;
  logic [W-1:0] srt1, srt2, srt3, srt4;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  always #5 clk = ~clk;

  sort_deskew_serializer #(.width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .grp_valid (grp_valid),
    .grp_ready (grp_ready),
    .sort_en   (sort_en),
    .srt1      (srt1),
    .srt2      (srt2),
    .srt3      (srt3),
    .srt4      (srt4),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  // Sorter model: group words already in sorted order, outputs staggered.
  grp_t in_grp = '0;
  grp_t s1 = '0;
  grp_t s2 = '0;
  grp_t s3 = '0;
  always @(posedge clk) begin
    if (sort_en) begin
      s1 <= in_grp;
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign srt4 = s1[3];
  assign srt3 = s2[2];
  assign srt1 = s3[0];
  assign srt2 = s3[1];

  // Reference model and bookkeeping.
  logic [W-1:0] exp_q[$];
  int           pos = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           accepted = 0;
  int           words_out = 0;
  int           groups_out = 0;
  bit           acc_now = 0;
  bit           need_new = 1;
  bit           held = 0;
  logic [W-1:0] held_data;
  logic         held_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic grp_t make_group();
    logic [W-1:0] w[4];
    logic [W-1:0] t;
    grp_t g;
    for (int k = 0; k < 4; k++) w[k] = W'($urandom);
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3 - a; b++)
        if (w[b] > w[b+1]) begin
          t = w[b]; w[b] = w[b+1]; w[b+1] = t;
        end
    for (int k = 0; k < 4; k++) g[k] = w[k];
    return g;
  endfunction

  // Compare process: inputs and outputs are stable at the falling edge, so the
  // handshakes about to happen on the next rising edge are evaluated here.
  always @(negedge clk) begin
    acc_now = 0;
    if (rst) begin
      check("grp_ready_eq_sort_en", grp_ready, sort_en);
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_data);
        check("hold_last", out_last, held_last);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_word_valid", out_valid, 0);
        end else begin
          check("word_data", out_data, exp_q[0]);
          check("word_last", out_last, pos == 3);
        end
      end else begin
        check("last_without_valid", out_last, 0);
      end
      if (out_valid && out_ready) begin
        words_out++;
        if (out_last) groups_out++;
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          pos = (pos + 1) % 4;
        end
      end
      if (grp_valid && grp_ready) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(in_grp[k]);
        accepted++;
        acc_now = 1;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
    end else begin
      held = 0;
    end
  end

  // One clock of stimulus; returns just after the rising edge.
  task automatic step(input bit v, input bit r);
    if (v && need_new) begin
      in_grp   = make_group();
      need_new = 0;
    end
    grp_valid = v;
    out_ready = r;
    @(posedge clk);
    #1;
    if (acc_now) need_new = 1;
  endtask

  // Asynchronous reset applied between edges; model state is discarded with it.
  task automatic apply_reset();
    #2;
    rst = 1'b0;
    exp_q.delete();
    pos      = 0;
    held     = 0;
    need_new = 1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sort_en", sort_en, 1);
    check("rst_grp_ready", grp_ready, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      step(0, 1);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_idle", out_valid, 0);
  endtask

  // Fixed group 0x10..0x13: first word three edges after acceptance, then one
  // word per edge with out_last only on the fourth.
  task automatic single_group();
    in_grp   = {8'h13, 8'h12, 8'h11, 8'h10};
    need_new = 0;
    step(1, 1);
    check("sg_e0_valid", out_valid, 0);
    step(0, 1);
    check("sg_e1_valid", out_valid, 0);
    step(0, 1);
    check("sg_e2_valid", out_valid, 0);
    step(0, 1);
    for (int w = 0; w < 4; w++) begin
      check("sg_valid", out_valid, 1);
      check("sg_data", out_data, 32'h10 + w);
      check("sg_last", out_last, w == 3);
      step(0, 1);
    end
    check("sg_after_valid", out_valid, 0);
  endtask

  initial begin
    int g0;
    int acc0;
    int n;
    rst       = 1'b1;
    grp_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // Single group latency and word order.
    single_group();

    // Three back-to-back groups with distinct values.
    g0 = groups_out;
    for (int gi = 1; gi <= 3; gi++) begin
      in_grp   = {W'(16*gi+3), W'(16*gi+2), W'(16*gi+1), W'(16*gi)};
      need_new = 0;
      step(1, 1);
    end
    drain();
    check("skew_groups", groups_out - g0, 3);

    // Backpressure: buffer fills, the third group stalls at the pipeline end.
    acc0 = accepted;
    g0   = groups_out;
    step(1, 0);
    step(1, 0);
    step(1, 0);
    step(1, 0);
    check("bp_e3_valid", out_valid, 1);
    check("bp_e3_sort_en", sort_en, 1);
    step(1, 0);
    check("bp_e4_sort_en", sort_en, 0);
    step(1, 0);
    check("bp_e5_sort_en", sort_en, 0);
    step(1, 1);
    step(1, 1);
    step(1, 1);
    check("bp_pre_pop_sort_en", sort_en, 0);
    step(1, 1);
    check("bp_post_pop_sort_en", sort_en, 1);
    n = 0;
    while (accepted - acc0 < 6 && n < 200) begin
      step(1, 1);
      n++;
    end
    check("bp_accept_timeout", accepted - acc0 >= 6, 1);
    drain();
    check("bp_groups", groups_out - g0, accepted - acc0);

    // Randomised handshakes on both sides.
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
    end
    drain();
    check("word_total", words_out, 4 * accepted);

    // Gaps in the offered groups.
    g0 = groups_out;
    step(1, 1);
    step(0, 1);
    step(0, 1);
    step(1, 1);
    drain();
    check("gap_groups", groups_out - g0, 2);

    // Reset during the second word of a group while another group is stalled.
    n = 0;
    while (sort_en && n < 20) begin
      step(1, 0);
      n++;
    end
    check("rst_stall_reached", sort_en, 0);
    step(0, 1);
    check("rst_mid_word_valid", out_valid, 1);
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      check("rst_no_stale", out_valid, 0);
      step(0, 1);
    end
    single_group();
    check("word_total_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
